regfile_sb: RTL and testbench

//  Parametrised 2-read/1-write CPU register file with a per-register pending-write scoreboard.
//  - Issue stage marks a destination register busy.
//  - Writeback writes the data and clears the busy bit.
//  - Decode reads operands plus busy flags for stall detection.
//  - Optional same-cycle writeback-to-read bypass.
//  - Flush clears all pending marks.

---
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with a per-register pending-write scoreboard.
// Issue marks a destination busy; writeback writes data and clears the mark.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic [AW-1:0] i_rna,
  input  logic [AW-1:0] i_rnb,
  output logic [DW-1:0] o_qa,
  output logic [DW-1:0] o_qb,
  output logic          o_busy_a,
  output logic          o_busy_b,
  input  logic          i_iss,
  input  logic [AW-1:0] i_isn,
  input  logic          i_we,
  input  logic [AW-1:0] i_wn,
  input  logic [DW-1:0] i_d,
  input  logic          i_flush,
  output logic [AW:0]   o_nbusy
);

  localparam int   N  = 1 << AW;
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  logic [DW-1:0] r_mem [N];
  logic [N-1:0]  r_busy;
  logic [AW:0]   r_nbusy;

  logic          w_we_ok;
  logic          w_iss_ok;
  logic          w_same;
  logic          w_set;
  logic          w_unset;
  logic [N-1:0]  w_busy_nxt;
  logic [AW:0]   w_nbusy_nxt;
  logic          w_zero_a;
  logic          w_zero_b;
  logic          w_hit_a;
  logic          w_hit_b;

  // Register 0 strobes are swallowed here so nothing below special-cases it.
  assign w_we_ok  = i_we  & ~(ZR & (i_wn  == '0));
  assign w_iss_ok = i_iss & ~(ZR & (i_isn == '0));
  assign w_same   = (i_isn == i_wn);

  assign w_set   = w_iss_ok & ~r_busy[i_isn];
  assign w_unset = w_we_ok & r_busy[i_wn]
                 & ~(w_iss_ok & w_same);

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_we_ok)
        w_busy_nxt[i_wn] = 1'b0;
      // Applied after the clear: a newer producer wins.
      if (w_iss_ok)
        w_busy_nxt[i_isn] = 1'b1;
    end
  end

  always_comb begin
    w_nbusy_nxt = r_nbusy;
    if (i_flush)
      w_nbusy_nxt = '0;
    else
      w_nbusy_nxt = r_nbusy
                  + (AW+1)'(w_set)
                  - (AW+1)'(w_unset);
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_busy  <= '0;
      r_nbusy <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_nbusy <= w_nbusy_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      for (int i = 0; i < N; i++)
        r_mem[i] <= '0;
    end else if (w_we_ok) begin
      r_mem[i_wn] <= i_d;
    end
  end

  assign w_zero_a = ZR & (i_rna == '0);
  assign w_zero_b = ZR & (i_rnb == '0);
  assign w_hit_a  = BP & i_we & (i_wn == i_rna);
  assign w_hit_b  = BP & i_we & (i_wn == i_rnb);

  // Outputs are forced quiet while reset is held, bypass included.
  always_comb begin
    o_qa     = r_mem[i_rna];
    o_busy_a = r_busy[i_rna] & ~w_hit_a;
    if (i_clr || w_zero_a) begin
      o_qa     = '0;
      o_busy_a = 1'b0;
    end else if (w_hit_a) begin
      o_qa = i_d;
    end
  end

  always_comb begin
    o_qb     = r_mem[i_rnb];
    o_busy_b = r_busy[i_rnb] & ~w_hit_b;
    if (i_clr || w_zero_b) begin
      o_qb     = '0;
      o_busy_b = 1'b0;
    end else if (w_hit_b) begin
      o_qb = i_d;
    end
  end

  assign o_nbusy = r_nbusy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async reset sequence,
// then randomized traffic against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          clr;
  logic [AW-1:0] rna, rnb, isn, wn;
  logic [DW-1:0] qa, qb, d;
  logic          busy_a, busy_b, iss, we, flush;
  logic [AW:0]   nbusy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .i_clk(clk), .i_clr(clr),
    .i_rna(rna), .i_rnb(rnb),
    .o_qa(qa), .o_qb(qb),
    .o_busy_a(busy_a), .o_busy_b(busy_b),
    .i_iss(iss), .i_isn(isn),
    .i_we(we), .i_wn(wn), .i_d(d),
    .i_flush(flush), .o_nbusy(nbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iss;
    logic [AW-1:0] isn;
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] d;
    logic          fl;
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          ba;
    logic          bb;
    logic [AW:0]   nb;
  } vec_t;

  vec_t tv[$];

  // reference model state
  logic [DW-1:0] m_mem [N];
  bit            m_busy [N];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic i_, int in_, logic w_, int wn_, logic [31:0] d_, logic f_,
    int a_, int b_, logic [31:0] qa_, logic [31:0] qb_,
    logic ba_, logic bb_, int nb_);
    vec_t v;
    v.iss = i_;  v.isn = AW'(in_);
    v.we  = w_;  v.wn  = AW'(wn_);
    v.d   = d_;  v.fl  = f_;
    v.rna = AW'(a_); v.rnb = AW'(b_);
    v.qa  = qa_; v.qb  = qb_;
    v.ba  = ba_; v.bb  = bb_;
    v.nb  = (AW+1)'(nb_);
    return v;
  endfunction

  task automatic idle();
    iss = 0; isn = 0; we = 0; wn = 0;
    d = 0; flush = 0; rna = 0; rnb = 0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] m_q(logic [AW-1:0] rn);
    if (rn == 0) return '0;
    if (we && wn == rn) return d;
    return m_mem[rn];
  endfunction

  function automatic logic m_b(logic [AW-1:0] rn);
    if (rn == 0) return 1'b0;
    if (we && wn == rn) return 1'b0;
    return m_busy[rn];
  endfunction

  initial begin
    idle();
    clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end

    // inputs:  iss isn we wn d fl rna rnb | qa qb ba bb nb
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 0,1, 32'h0, 32'h0, 0,0, 0));
    tv.push_back(mk(0,0, 1,5, 32'hDEADBEEF, 0, 5,5,
                    32'hDEADBEEF, 32'hDEADBEEF, 0,0, 0));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 5,0, 32'hDEADBEEF, 32'h0, 0,0, 0));
    tv.push_back(mk(1,7, 0,0, 32'h0, 0, 7,5, 32'h0, 32'hDEADBEEF, 0,0, 0));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 7,5, 32'h0, 32'hDEADBEEF, 1,0, 1));
    tv.push_back(mk(0,0, 1,7, 32'h77, 0, 7,7, 32'h77, 32'h77, 0,0, 1));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 7,0, 32'h77, 32'h0, 0,0, 0));
    tv.push_back(mk(1,3, 1,3, 32'h1, 0, 3,3, 32'h1, 32'h1, 0,0, 0));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 3,7, 32'h1, 32'h77, 1,0, 1));
    tv.push_back(mk(1,0, 1,0, 32'hFFFFFFFF, 0, 0,3, 32'h0, 32'h1, 0,1, 1));
    tv.push_back(mk(0,0, 1,3, 32'h2, 0, 3,0, 32'h2, 32'h0, 0,0, 1));
    tv.push_back(mk(1,1, 0,0, 32'h0, 0, 1,0, 32'h0, 32'h0, 0,0, 0));
    tv.push_back(mk(1,2, 0,0, 32'h0, 0, 1,0, 32'h0, 32'h0, 1,0, 1));
    tv.push_back(mk(1,3, 0,0, 32'h0, 0, 2,0, 32'h0, 32'h0, 1,0, 2));
    tv.push_back(mk(1,4, 0,0, 32'h0, 0, 3,1, 32'h2, 32'h0, 1,1, 3));
    tv.push_back(mk(1,9, 0,0, 32'h0, 1, 4,9, 32'h0, 32'h0, 1,0, 4));
    tv.push_back(mk(1,4, 0,0, 32'h0, 0, 4,9, 32'h0, 32'h0, 0,0, 0));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 4,1, 32'h0, 32'h0, 1,0, 1));
    tv.push_back(mk(1,4, 0,0, 32'h0, 0, 4,3, 32'h0, 32'h2, 1,0, 1));
    tv.push_back(mk(0,0, 1,4, 32'h44, 1, 4,9, 32'h44, 32'h0, 0,0, 1));
    tv.push_back(mk(0,0, 0,0, 32'h0, 0, 4,0, 32'h44, 32'h0, 0,0, 0));

    // outputs while reset is held
    #12;
    chk("rst qa", 64'(qa), 64'h0);
    chk("rst busy_a", 64'(busy_a), 64'h0);
    chk("rst nbusy", 64'(nbusy), 64'h0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      iss = tv[i].iss; isn = tv[i].isn;
      we  = tv[i].we;  wn  = tv[i].wn;
      d   = tv[i].d;   flush = tv[i].fl;
      rna = tv[i].rna; rnb = tv[i].rnb;
      @(negedge clk);
      chk($sformatf("v%0d qa", i), 64'(qa), 64'(tv[i].qa));
      chk($sformatf("v%0d qb", i), 64'(qb), 64'(tv[i].qb));
      chk($sformatf("v%0d busy_a", i), 64'(busy_a), 64'(tv[i].ba));
      chk($sformatf("v%0d busy_b", i), 64'(busy_b), 64'(tv[i].bb));
      chk($sformatf("v%0d nbusy", i), 64'(nbusy), 64'(tv[i].nb));
      @(posedge clk);
      #1;
    end

    // async reset mid-cycle after a pending issue
    idle();
    iss = 1; isn = 6;
    @(posedge clk);
    #1;
    idle();
    rna = 6; rnb = 4;
    @(negedge clk);
    chk("pre clr busy_a", 64'(busy_a), 64'h1);
    chk("pre clr qb", 64'(qb), 64'h44);
    chk("pre clr nbusy", 64'(nbusy), 64'h1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr qa", 64'(qa), 64'h0);
    chk("clr qb", 64'(qb), 64'h0);
    chk("clr busy_a", 64'(busy_a), 64'h0);
    chk("clr busy_b", 64'(busy_b), 64'h0);
    chk("clr nbusy", 64'(nbusy), 64'h0);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    rna = 5; rnb = 6;
    @(negedge clk);
    chk("post clr r5", 64'(qa), 64'h0);
    chk("post clr busy6", 64'(busy_b), 64'h0);
    @(posedge clk);
    #1;

    // randomized traffic vs model (model zeroed, matching the reset)
    for (int c = 0; c < 3000; c++) begin
      bit wide;
      wide  = ($urandom_range(0, 3) == 0);
      iss   = ($urandom_range(0, 9) < 4);
      we    = ($urandom_range(0, 9) < 5);
      flush = ($urandom_range(0, 31) == 0);
      isn   = AW'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wn    = AW'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
      rna   = AW'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
      rnb   = AW'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
      d     = $urandom;
      @(negedge clk);
      chk("rnd qa", 64'(qa), 64'(m_q(rna)));
      chk("rnd qb", 64'(qb), 64'(m_q(rnb)));
      chk("rnd busy_a", 64'(busy_a), 64'(m_b(rna)));
      chk("rnd busy_b", 64'(busy_b), 64'(m_b(rnb)));
      chk("rnd nbusy", 64'(nbusy), 64'(m_count()));
      @(posedge clk);
      if (we && wn != 0) m_mem[wn] = d;
      if (flush) begin
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      end else begin
        if (we && wn != 0) m_busy[wn] = 1'b0;
        if (iss && isn != 0) m_busy[isn] = 1'b1;
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
